// File: rtl/stage_update_writer.sv
// Stage update writer: commits single-word updates to one of STAGES lookup-stage BRAMs.
// Optional READBACK_VERIFY_EN reads the word back and reports the comparison in rsp_ok.
module stage_update_writer #(
  parameter int unsigned DATA   = 72,
  parameter int unsigned ADDR   = 10,
  parameter int unsigned STAGES = 4,
  localparam int unsigned SW    = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [SW-1:0]            cmd_stage,
  input  logic [ADDR-1:0]          cmd_addr,
  input  logic [DATA-1:0]          cmd_data,
  output logic [STAGES-1:0]        mem_wr,
  output logic [ADDR-1:0]          mem_addr,
  output logic [DATA-1:0]          mem_din,
  input  logic [STAGES*DATA-1:0]   mem_dout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_ok,
  output logic [15:0]              wr_count,
  output logic [15:0]              err_count,
  output logic                     busy
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWrite = 3'd1;
`ifdef READBACK_VERIFY_EN
  localparam logic [2:0] StRead  = 3'd2;
  localparam logic [2:0] StCheck = 3'd3;
`endif
  localparam logic [2:0] StResp  = 3'd4;

  localparam logic [SW:0] StagesW = (SW + 1)'(STAGES);

  logic [2:0]      state_q, state_d;
  logic            init_q;
  logic [SW-1:0]   stage_q;
  logic [ADDR-1:0] addr_q;
  logic [DATA-1:0] data_q;
  logic            ok_q;
  logic [15:0]     wr_count_q;
  logic [15:0]     err_count_q;
  logic            accept;
  logic            in_range;

  // init_q holds cmd_ready low until the first edge after reset release.
  assign cmd_ready = init_q && (state_q == StIdle);
  assign accept    = cmd_valid && cmd_ready;
  assign in_range  = {1'b0, cmd_stage} < StagesW;

`ifdef READBACK_VERIFY_EN
  logic [DATA-1:0] rd_word;
  assign rd_word = mem_dout[32'(stage_q) * DATA +: DATA];
`else
  logic unused_mem_dout;
  assign unused_mem_dout = ^mem_dout;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = in_range ? StWrite : StResp;
`ifdef READBACK_VERIFY_EN
      StWrite: state_d = StRead;
      StRead:  state_d = StCheck;
      StCheck: state_d = StResp;
`else
      StWrite: state_d = StResp;
`endif
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      init_q      <= 1'b0;
      stage_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      ok_q        <= 1'b0;
      wr_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      if (accept) begin
        stage_q <= cmd_stage;
        addr_q  <= cmd_addr;
        data_q  <= cmd_data;
        ok_q    <= 1'b0;
      end
      if (state_q == StWrite) begin
        if (wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
`ifndef READBACK_VERIFY_EN
        ok_q <= 1'b1;
`endif
      end
`ifdef READBACK_VERIFY_EN
      if (state_q == StCheck) ok_q <= (rd_word == data_q);
`endif
      if (state_q == StResp && rsp_ready && !ok_q && err_count_q != 16'hFFFF) begin
        err_count_q <= err_count_q + 16'd1;
      end
    end
  end

  always_comb begin
    mem_wr = '0;
    for (int s = 0; s < STAGES; s++) begin
      mem_wr[s] = (state_q == StWrite) && (32'(stage_q) == s);
    end
  end

  assign mem_addr  = addr_q;
  assign mem_din   = data_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_ok    = ok_q;
  assign wr_count  = wr_count_q;
  assign err_count = err_count_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_stage_update_writer.sv
// Bench for stage_update_writer: vector table, hand sequences and random commands
// checked against a behavioural BRAM and response model.
module tb_stage_update_writer;

  // Five stages so that out-of-range stage numbers (5..7) fit in the 3-bit cmd_stage.
  localparam int DATA   = 72;
  localparam int ADDR   = 10;
  localparam int STAGES = 5;
  localparam int SW     = 3;
`ifdef READBACK_VERIFY_EN
  localparam int LAT    = 4;
  localparam bit VERIFY = 1'b1;
`else
  localparam int LAT    = 2;
  localparam bit VERIFY = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   cmd_valid = 1'b0;
  logic                   cmd_ready;
  logic [SW-1:0]          cmd_stage = '0;
  logic [ADDR-1:0]        cmd_addr = '0;
  logic [DATA-1:0]        cmd_data = '0;
  logic [STAGES-1:0]      mem_wr;
  logic [ADDR-1:0]        mem_addr;
  logic [DATA-1:0]        mem_din;
  logic [STAGES*DATA-1:0] mem_dout;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b1;
  logic                   rsp_ok;
  logic [15:0]            wr_count;
  logic [15:0]            err_count;
  logic                   busy;

  always #5 clk = ~clk;

  stage_update_writer #(.DATA(DATA), .ADDR(ADDR), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_stage (cmd_stage),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_ok    (rsp_ok),
    .wr_count  (wr_count),
    .err_count (err_count),
    .busy      (busy)
  );

  // Behavioural stage BRAMs with registered read; 'corrupt' makes stage 1 read back zero.
  logic [DATA-1:0] mem [STAGES][2**ADDR];
  logic [DATA-1:0] dout_r [STAGES];
  bit              corrupt = 1'b0;

  initial begin
    for (int s = 0; s < STAGES; s++) begin
      dout_r[s] = '0;
      for (int a = 0; a < 2**ADDR; a++) mem[s][a] = '0;
    end
  end

  always @(posedge clk) begin
    for (int s = 0; s < STAGES; s++) begin
      if (mem_wr[s]) mem[s][mem_addr] <= mem_din;
      dout_r[s] <= (corrupt && s == 1) ? '0 : mem[s][mem_addr];
    end
  end

  always_comb begin
    mem_dout = '0;
    for (int s = 0; s < STAGES; s++) mem_dout[s*DATA +: DATA] = dout_r[s];
  end

  int checks = 0;
  int failures = 0;
  int exp_wr = 0;
  int exp_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit model_ok(input int stage, input logic [DATA-1:0] data, input bit bad);
    if (stage >= STAGES) return 1'b0;
    if (VERIFY && bad && stage == 1) return data == '0;
    return 1'b1;
  endfunction

  task automatic run_cmd(input string tag, input int stage, input logic [ADDR-1:0] addr,
                         input logic [DATA-1:0] data, input int hold, input bit bad,
                         input bit exp_ok);
    int first;
    int nwr;
    bit in_range;
    logic [STAGES-1:0] exp_vec;
    logic ok_seen;
    in_range = stage < STAGES;
    exp_vec = '0;
    if (in_range) exp_vec[stage] = 1'b1;
    corrupt = bad;
    @(negedge clk);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_stage = SW'(stage);
    cmd_addr  = addr;
    cmd_data  = data;
    rsp_ready = (hold == 0);
    @(posedge clk);
    first = 0;
    nwr = 0;
    for (int k = 1; k <= 10 && first == 0; k++) begin
      @(negedge clk);
      // Garbage on the command port while busy must be ignored.
      cmd_valid = 1'($urandom);
      cmd_stage = SW'($urandom);
      cmd_addr  = ADDR'($urandom);
      cmd_data  = {$urandom, $urandom, $urandom};
      if (mem_wr != '0) begin
        nwr++;
        chk({tag, "_mem_wr"}, mem_wr, exp_vec);
        chk({tag, "_wr_cycle"}, k, 1);
        chk({tag, "_mem_din"}, mem_din, data);
      end
      if (in_range && k < LAT) chk({tag, "_mem_addr"}, mem_addr, addr);
      if (rsp_valid) begin
        first = k;
        cmd_valid = 1'b0;
      end
    end
    chk({tag, "_nwr"}, nwr, in_range ? 1 : 0);
    if (first == 0) begin
      chk({tag, "_rsp_timeout"}, 0, 1);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      return;
    end
    if (in_range) chk({tag, "_latency"}, first, LAT);
    else chk({tag, "_reject_latency_le2"}, (first <= 2), 1);
    chk({tag, "_rsp_ok"}, rsp_ok, exp_ok);
    ok_seen = rsp_ok;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_state"}, {rsp_valid, rsp_ok, cmd_ready}, {1'b1, ok_seen, 1'b0});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (in_range && exp_wr < 16'hFFFF) exp_wr++;
    if (!exp_ok && exp_err < 16'hFFFF) exp_err++;
    chk({tag, "_idle"}, {rsp_valid, cmd_ready, busy}, 3'b010);
    chk({tag, "_wr_count"}, wr_count, exp_wr);
    chk({tag, "_err_count"}, err_count, exp_err);
    if (in_range) chk({tag, "_mem_content"}, mem[stage][addr], data);
  endtask

  typedef struct {
    string           tag;
    int              stage;
    logic [ADDR-1:0] addr;
    logic [DATA-1:0] data;
    int              hold;
    bit              bad;
    bit              exp_ok;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{"basic_s2", 2, 10'h005, 72'hAB, 0, 1'b0, 1'b1};
    tbl[1] = '{"readback_bad_s1", 1, 10'h3FF, 72'hFF_FFFF_FFFF_FFFF_FFFF, 0, 1'b1, !VERIFY};
    tbl[2] = '{"oor_s5", 5, 10'h001, 72'h55, 0, 1'b0, 1'b0};
    tbl[3] = '{"hold10_s0", 0, 10'h000, 72'h12_3456_789A_BCDE_F012, 10, 1'b0, 1'b1};
    tbl[4] = '{"oor_s7_hold", 7, 10'h2AA, 72'h1, 3, 1'b0, 1'b0};
    tbl[5] = '{"top_s4", 4, 10'h200, 72'h80_0000_0000_0000_0001, 0, 1'b0, 1'b1};

    // Reset values while rst_n is held low.
    repeat (3) @(negedge clk);
    chk("rst_outputs", {mem_wr, rsp_valid, rsp_ok, busy, cmd_ready}, '0);
    chk("rst_addr_din", {mem_addr, mem_din}, '0);
    chk("rst_counts", {wr_count, err_count}, '0);
    rst_n = 1'b1;
    chk("rst_release_ready_low", cmd_ready, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_release_ready_high", cmd_ready, 1);

    foreach (tbl[i]) begin
      run_cmd(tbl[i].tag, tbl[i].stage, tbl[i].addr, tbl[i].data, tbl[i].hold, tbl[i].bad,
              tbl[i].exp_ok);
    end

    for (int n = 0; n < 30; n++) begin
      int st;
      logic [ADDR-1:0] ad;
      logic [DATA-1:0] dt;
      bit bd;
      st = $urandom_range(0, 7);
      ad = ADDR'($urandom);
      dt = {$urandom, $urandom, $urandom};
      bd = 1'($urandom);
      run_cmd("rand", st, ad, dt, $urandom_range(0, 2), bd, model_ok(st, dt, bd));
    end

    // Reset in the middle of a command (second cycle after accept).
    corrupt = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_stage = 3'd3;
    cmd_addr  = 10'h0CC;
    cmd_data  = 72'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {mem_wr, rsp_valid, cmd_ready, busy}, '0);
    chk("midrst_counts", {wr_count, err_count}, '0);
    chk("midrst_write_kept", mem[3][10'h0CC], 72'hDEAD_BEEF);
    exp_wr = 0;
    exp_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_ready_low", cmd_ready, 0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ready_high", {cmd_ready, rsp_valid}, 2'b10);

    // Saturation of wr_count.
    force dut.wr_count_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.wr_count_q;
    exp_wr = 16'hFFFF;
    run_cmd("wr_sat", 2, 10'h011, 72'h77, 0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
